restoring_divider_8x4: RTL and testbench

//  Sequential unsigned restoring divider. It is the inverse companion to the 4x4

---
 rtl/restoring_divider_8x4_if.sv | 23 ++
 rtl/restoring_divider_8x4.sv | 140 ++++++++++++++
 tb/tb_restoring_divider_8x4.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/restoring_divider_8x4_if.sv
// Start/busy/done handshake and operand/result bus for the restoring divider.
interface restoring_divider_8x4_if #(
    parameter int unsigned W = 4
);
    logic             start;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   q;
    logic [W-1:0]     r;
    logic             dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, q, r, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, q, r, dbz
    );
endinterface

// File: rtl/restoring_divider_8x4.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module restoring_divider_8x4 #(
    parameter int unsigned W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    restoring_divider_8x4_if.slave  div_if
);
    localparam int unsigned NW = 2 * W;
    localparam int unsigned CW = $clog2(NW + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic [W-1:0]    d_q, d_d;
    logic [W:0]      pr_q, pr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            zdiv_q, zdiv_d;
    logic [NW-1:0]   q_q, q_d;
    logic [W-1:0]    r_q, r_d;
    logic            dbz_q, dbz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            accept_c;
    logic            last_c;
    logic            ge_c;
    logic [W:0]      pr_sh_c;
    logic [W:0]      pr_sub_c;
    logic [NW-1:0]   n_sh_c;

    assign accept_c = div_if.start && (state_q != S_RUN);
    assign last_c   = (cnt_q == CW'(1));

    // One restoring step: shift in the dividend MSB, subtract if it fits.
    // The quotient bit is shifted into the vacated LSB of the dividend register.
    always_comb begin
        pr_sh_c  = {pr_q[W-1:0], n_q[NW-1]};
        ge_c     = (pr_sh_c >= {1'b0, d_q});
        pr_sub_c = ge_c ? (pr_sh_c - {1'b0, d_q}) : pr_sh_c;
        n_sh_c   = {n_q[NW-2:0], ge_c};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept_c) state_d = S_RUN;
            S_RUN:   if (last_c)   state_d = S_DONE;
            S_DONE:  state_d = accept_c ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, registered below so busy/done change with the state
    always_comb begin
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // Datapath next-state. A zero divisor spends a single settle cycle in RUN
    // without iterating, so its done lands one cycle after acceptance.
    always_comb begin
        n_d    = n_q;
        d_d    = d_q;
        pr_d   = pr_q;
        cnt_d  = cnt_q;
        zdiv_d = zdiv_q;
        q_d    = q_q;
        r_d    = r_q;
        dbz_d  = dbz_q;
        if (accept_c) begin
            n_d    = div_if.dividend;
            d_d    = div_if.divisor;
            pr_d   = '0;
            zdiv_d = (div_if.divisor == '0);
            cnt_d  = (div_if.divisor == '0) ? CW'(1) : CW'(NW);
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q - CW'(1);
            if (!zdiv_q) begin
                n_d  = n_sh_c;
                pr_d = pr_sub_c;
            end
            if (last_c) begin
                if (zdiv_q) begin
                    q_d   = '1;
                    r_d   = '0;
                    dbz_d = 1'b1;
                end else begin
                    q_d   = n_sh_c;
                    r_d   = pr_sub_c[W-1:0];
                    dbz_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q    <= '0;
            d_q    <= '0;
            pr_q   <= '0;
            cnt_q  <= '0;
            zdiv_q <= 1'b0;
            q_q    <= '0;
            r_q    <= '0;
            dbz_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            n_q    <= n_d;
            d_q    <= d_d;
            pr_q   <= pr_d;
            cnt_q  <= cnt_d;
            zdiv_q <= zdiv_d;
            q_q    <= q_d;
            r_q    <= r_d;
            dbz_q  <= dbz_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign div_if.busy = busy_q;
    assign div_if.done = done_q;
    assign div_if.q    = q_q;
    assign div_if.r    = r_q;
    assign div_if.dbz  = dbz_q;
endmodule

// File: tb/tb_restoring_divider_8x4.sv
// Directed bench for restoring_divider_8x4 with hand-computed expectations
// plus a full operand sweep against integer division.
module tb_restoring_divider_8x4;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    restoring_divider_8x4_if #(.W(W)) dif();

    restoring_divider_8x4 #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (dif)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Called at a falling edge; counts rising edges until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (dif.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input int n, input int d, input int exp_lat,
                          input int exp_q, input int exp_r, input int exp_dbz);
        int lat;
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 8'(n);
        dif.divisor  = 4'(d);
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        wait_done(lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_q"},   32'(dif.q),   32'(exp_q));
        check_eq({tag, "_r"},   32'(dif.r),   32'(exp_r));
        check_eq({tag, "_dbz"}, 32'(dif.dbz), 32'(exp_dbz));
    endtask

    initial begin
        int lat;
        int lat2;
        int pulses;
        logic [7:0] seen_q;
        logic [3:0] seen_r;

        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(dif.busy), 32'd0);
        check_eq("rst_done", 32'(dif.done), 32'd0);
        check_eq("rst_q",    32'(dif.q),    32'd0);
        check_eq("rst_r",    32'(dif.r),    32'd0);
        check_eq("rst_dbz",  32'(dif.dbz),  32'd0);
        rst = 1'b0;

        // Basic results and latency
        run_op("t1_200_7", 200, 7, 8, 28, 4, 0);
        run_op("t2_255_1", 255, 1, 8, 255, 0, 0);
        run_op("t2_15_15", 15, 15, 8, 1, 0, 0);
        run_op("t2_0_5",   0, 5, 8, 0, 0, 0);
        run_op("t2_14_15", 14, 15, 8, 0, 14, 0);
        run_op("t3_dbz",   100, 0, 1, 255, 0, 1);
        run_op("t3_9_2",   9, 2, 8, 4, 1, 0);

        // Mid-RUN start with new operands is ignored; operand changes ignored
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 8'd50; dif.divisor = 4'd3;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        check_eq("t4_busy", 32'(dif.busy), 32'd1);
        repeat (2) @(negedge clk);
        dif.start = 1'b1; dif.dividend = 8'd255; dif.divisor = 4'd1;
        @(negedge clk);
        dif.start = 1'b0; dif.dividend = 8'd0; dif.divisor = 4'd0;
        pulses = 0; seen_q = '0; seen_r = '0;
        for (int i = 0; i < 16; i++) begin
            if (dif.done === 1'b1) begin
                pulses++;
                seen_q = dif.q;
                seen_r = dif.r;
            end
            @(negedge clk);
        end
        check_eq("t4_pulses", 32'(pulses), 32'd1);
        check_eq("t4_q", 32'(seen_q), 32'd16);
        check_eq("t4_r", 32'(seen_r), 32'd2);
        check_eq("t4_dbz", 32'(dif.dbz), 32'd0);

        // Back-to-back: start held through DONE
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 8'd200; dif.divisor = 4'd7;
        @(posedge clk);
        @(negedge clk);
        wait_done(lat);
        check_eq("t5_lat1", 32'(lat), 32'd8);
        check_eq("t5_q1", 32'(dif.q), 32'd28);
        check_eq("t5_r1", 32'(dif.r), 32'd4);
        dif.dividend = 8'd9; dif.divisor = 4'd2;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        check_eq("t5_done_low", 32'(dif.done), 32'd0);
        check_eq("t5_busy", 32'(dif.busy), 32'd1);
        wait_done(lat2);
        check_eq("t5_gap", 32'(lat2 + 1), 32'd9);
        check_eq("t5_q2", 32'(dif.q), 32'd4);
        check_eq("t5_r2", 32'(dif.r), 32'd1);

        // Reset in the middle of RUN aborts without a done
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 8'd200; dif.divisor = 4'd7;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_busy", 32'(dif.busy), 32'd0);
        check_eq("t6_done", 32'(dif.done), 32'd0);
        check_eq("t6_q",    32'(dif.q),    32'd0);
        check_eq("t6_r",    32'(dif.r),    32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (dif.done === 1'b1) pulses++;
        end
        check_eq("t6_no_done", 32'(pulses), 32'd0);

        // Zero divisor flag clears on the next real division
        run_op("t7_dbz", 7, 0, 1, 255, 0, 1);
        run_op("t7_clr", 255, 15, 8, 17, 0, 0);

        // Full sweep of non-zero divisors against integer division
        for (int n = 0; n < 256; n++) begin
            for (int d = 1; d < 16; d++) begin
                run_op("sweep", n, d, 8, n / d, n % d, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
